dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving the MEM stage of the 5-stage pipeline. It accepts one load or store per request, holds `stall` high for a fixed latency so every pipeline register freezes, then completes the access in a single non-stall cycle. It is the memory-side end of the MemOp/MemWrite/stall interface driven by the MEM stage.

---
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Brief    : MEM-stage <-> data-memory request/response bundle
//             (MemOp/MemWrite request side, stall/load-data response side).
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        enable;
  logic        wr;
  logic [15:0] data_out;
  logic        stall;

  // MEM stage drives the request and consumes stall/load data
  modport master (
    output addr, data_in, enable, wr,
    input  data_out, stall
  );

  // Memory responder consumes the request and produces stall/load data
  modport slave (
    input  addr, data_in, enable, wr,
    output data_out, stall
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Fixed-latency data-memory responder. Freezes the pipeline for
//             LATENCY cycles per access, then completes the load/store in a
//             single non-stall cycle.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int c_CNT_W = $clog2(LATENCY + 1);
  localparam int c_WORDS = 2 ** DEPTH_LOG2;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // The request cycle itself is the first stall cycle, so the counter holds
  // the number of stall cycles still to come after the accept edge.
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

  logic [15:0]         r_mem [0:c_WORDS-1];
  logic [1:0]          r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [15:0]         r_addr;
  logic [15:0]         r_data;
  logic                r_wr;
  logic [15:0]         r_dout;
  logic                w_stall;

  logic [DEPTH_LOG2-1:0] w_in_idx;
  logic [DEPTH_LOG2-1:0] w_lat_idx;
  logic                  w_unused_bits;

  // Word index: byte-lane bit and upper address bits are dropped (aliasing)
  assign w_in_idx      = bus.addr[DEPTH_LOG2:1];
  assign w_lat_idx     = r_addr[DEPTH_LOG2:1];
  assign w_unused_bits = ^{r_addr, bus.addr};

  // Sequencer: accept, count down the stall window, complete in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= c_CNT_ZERO;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_wr    <= 1'b0;
      r_dout  <= 16'h0000;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.enable) begin
            r_addr <= bus.addr;
            r_data <= bus.data_in;
            r_wr   <= bus.wr;
            r_cnt  <= c_CNT_LOAD;
            if (c_CNT_LOAD == c_CNT_ZERO) begin
              // Single-cycle latency: the accept edge is also the final
              // stall edge, so the load result is captured right here.
              r_state <= c_DONE;
              if (!bus.wr) begin
                r_dout <= r_mem[w_in_idx];
              end
            end else begin
              r_state <= c_BUSY;
            end
          end
        end
        c_BUSY: begin
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            r_state <= c_DONE;
            if (!r_wr) begin
              r_dout <= r_mem[w_lat_idx];
            end
          end
        end
        c_DONE: begin
          // Enable is still high for the same instruction; never retrigger
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Store commits on the edge leaving DONE; a reset on that edge drops it
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == c_DONE) && r_wr) begin
      r_mem[w_lat_idx] <= r_data;
    end
  end

  // Stall: raised by a new request in IDLE, held through BUSY, low in DONE
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      c_IDLE:  w_stall = bus.enable;
      c_BUSY:  w_stall = 1'b1;
      c_DONE:  w_stall = 1'b0;
      default: w_stall = bus.enable;
    endcase
  end

  assign bus.stall    = w_stall;
  assign bus.data_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Self-checking bench for dmem_responder. Two instances:
//             index 0 with LATENCY=4, index 1 with LATENCY=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  logic clk;
  logic rst_n;

  logic        en  [2];
  logic [15:0] ad  [2];
  logic [15:0] di  [2];
  logic        wrr [2];

  int total;
  int bad;

  // Reference model: word-indexed array plus written flags, last load result
  logic [15:0] mdl  [2][1024];
  bit          vld  [2][1024];
  logic [15:0] last [2];

  dmem_responder_if bus4 ();
  dmem_responder_if bus1 ();

  assign bus4.addr    = ad[0];
  assign bus4.data_in = di[0];
  assign bus4.enable  = en[0];
  assign bus4.wr      = wrr[0];
  assign bus1.addr    = ad[1];
  assign bus1.data_in = di[1];
  assign bus1.enable  = en[1];
  assign bus1.wr      = wrr[1];

  dmem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wr;
    logic [15:0] exp;
  } vec_t;

  function automatic logic stall_of(input int s);
    return (s == 0) ? bus4.stall : bus1.stall;
  endfunction

  function automatic logic [15:0] dout_of(input int s);
    return (s == 0) ? bus4.data_out : bus1.data_out;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete access starting right after a rising edge. Inputs other
  // than enable are scrambled after every stall edge; the DUT must ignore it.
  task automatic access(input int s, input logic [15:0] a, input logic [15:0] d,
                        input logic w, input logic keep, output logic [15:0] got);
    int          lat;
    logic [9:0]  idx;
    logic [15:0] exp;
    lat = (s == 0) ? 4 : 1;
    idx = a[10:1];
    exp = w ? last[s] : mdl[s][idx];
    en[s] = 1'b1; ad[s] = a; di[s] = d; wrr[s] = w;
    got = 16'h0000;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk(w ? "store_stall" : "load_stall", {15'b0, stall_of(s)}, {15'b0, (c < lat)});
      if (c == lat) begin
        got = dout_of(s);
        if (w || vld[s][idx]) chk(w ? "store_dout_hold" : "load_data", got, exp);
      end
      @(posedge clk); #1;
      if (c < lat) begin
        ad[s]  = 16'($urandom);
        di[s]  = 16'($urandom);
        wrr[s] = 1'($urandom);
      end
    end
    if (w) begin
      mdl[s][idx] = d;
      vld[s][idx] = 1'b1;
    end else if (vld[s][idx]) begin
      last[s] = exp;
    end
    if (!keep) en[s] = 1'b0;
  endtask

  vec_t        tbl [9];
  logic [15:0] got;
  logic [15:0] ra;
  logic [3:0]  ridx;
  logic        rw;

  initial begin
    total = 0;
    bad   = 0;
    for (int s = 0; s < 2; s++) begin
      en[s] = 1'b0; ad[s] = 16'h0000; di[s] = 16'h0000; wrr[s] = 1'b0;
      last[s] = 16'h0000;
    end

    // Directed vector table (LATENCY=4 instance), run back to back
    tbl[0] = '{addr:16'h0010, data:16'hBEEF, wr:1'b1, exp:16'h0000};
    tbl[1] = '{addr:16'h0010, data:16'h0000, wr:1'b0, exp:16'hBEEF};
    tbl[2] = '{addr:16'h0020, data:16'hAAAA, wr:1'b1, exp:16'hBEEF};
    tbl[3] = '{addr:16'h0010, data:16'h0000, wr:1'b0, exp:16'hBEEF};
    tbl[4] = '{addr:16'h0020, data:16'h0000, wr:1'b0, exp:16'hAAAA};
    tbl[5] = '{addr:16'h0011, data:16'h1234, wr:1'b1, exp:16'hAAAA};
    tbl[6] = '{addr:16'h0010, data:16'h0000, wr:1'b0, exp:16'h1234};
    tbl[7] = '{addr:16'h0810, data:16'h0000, wr:1'b0, exp:16'h1234};
    tbl[8] = '{addr:16'h0011, data:16'h0000, wr:1'b0, exp:16'h1234};

    // Reset: two cycles low, enable low -> no stall, data_out cleared
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_stall4", {15'b0, bus4.stall}, 16'h0000);
    chk("reset_stall1", {15'b0, bus1.stall}, 16'h0000);
    chk("reset_dout4", bus4.data_out, 16'h0000);
    chk("reset_dout1", bus1.data_out, 16'h0000);
    en[0] = 1'b1;
    #1;
    chk("reset_idle_stall_en", {15'b0, bus4.stall}, 16'h0001);
    @(posedge clk); #1;
    en[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: store/load, mid-access input changes, aliasing and odd address
    for (int i = 0; i < 9; i++) begin
      access(0, tbl[i].addr, tbl[i].data, tbl[i].wr, (i != 8), got);
      chk($sformatf("table[%0d]_dout", i), got, tbl[i].exp);
    end
    @(posedge clk); #1;

    // Reset in the middle of a store: store is dropped, data_out cleared
    access(0, 16'h0030, 16'h7777, 1'b1, 1'b0, got);
    en[0] = 1'b1; ad[0] = 16'h0030; di[0] = 16'h5555; wrr[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midstore_busy_stall", {15'b0, bus4.stall}, 16'h0001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    en[0] = 1'b0;
    @(negedge clk);
    chk("post_reset_stall", {15'b0, bus4.stall}, 16'h0000);
    chk("post_reset_dout", bus4.data_out, 16'h0000);
    last[0] = 16'h0000;
    last[1] = 16'h0000;
    @(posedge clk); #1;
    access(0, 16'h0030, 16'h0000, 1'b0, 1'b0, got);
    chk("aborted_store_dropped", got, 16'h7777);

    // LATENCY=1: three loads with enable held high -> stall 1,0,1,0,1,0
    access(1, 16'h0040, 16'h1111, 1'b1, 1'b0, got);
    access(1, 16'h0042, 16'h2222, 1'b1, 1'b0, got);
    access(1, 16'h0044, 16'h3333, 1'b1, 1'b0, got);
    access(1, 16'h0040, 16'h0000, 1'b0, 1'b1, got);
    chk("lat1_load0", got, 16'h1111);
    access(1, 16'h0042, 16'h0000, 1'b0, 1'b1, got);
    chk("lat1_load1", got, 16'h2222);
    access(1, 16'h0044, 16'h0000, 1'b0, 1'b0, got);
    chk("lat1_load2", got, 16'h3333);
    @(negedge clk);
    chk("lat1_idle_after", {15'b0, bus1.stall}, 16'h0000);
    @(posedge clk); #1;

    // Randomized traffic on both instances against the array model
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        ridx = 4'($urandom_range(0, 7));
        ra = 16'($urandom);
        ra[10:1] = {6'b0, ridx};
        rw = 1'($urandom);
        if (!vld[s][{6'b0, ridx}]) rw = 1'b1;
        access(s, ra, 16'($urandom), rw, 1'($urandom), got);
      end
      en[s] = 1'b0;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
